alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-002 SHALL have port instr_valid, in, 1: instruction offered.
REQ-003 SHALL have port instr_ready, out, 1: sequencer can accept an instruction.
REQ-004 SHALL have ports instr_op (in, 4: ALU select code), instr_rd (in, 2: destination register), instr_rs (in, 2: source A) and instr_rt (in, 2: source B).
REQ-005 SHALL have ports alu_a (out, 8), alu_b (out, 8), alu_select (out, 4) and alu_en (out, 1): drive the 8-bit ALU.
REQ-006 SHALL have ports alu_out (in, 8) and alu_cout (in, 1): ALU result and carry out.
REQ-007 SHALL have ports wr_en (in, 1), wr_addr (in, 2) and wr_data (in, 8): external register load.
REQ-008 SHALL have ports rd_addr (in, 2) and rd_data (out, 8): combinational register read.
REQ-009 SHALL have ports busy (out, 1), done (out, 1: one-cycle writeback pulse), carry_flag (out, 1) and op_err (out, 1: one-cycle illegal-op pulse).

Function
REQ-010 SHALL contain a 4 x 8-bit register file R0..R3.
REQ-011 SHALL implement FSM states IDLE, EXEC and WB, with IDLE->EXEC on instr_valid&instr_ready, EXEC->WB unconditionally, and WB->IDLE unconditionally.
REQ-012 SHALL drive instr_ready=1 only in IDLE and busy=~instr_ready.
REQ-013 SHALL register op/rd/rs/rt at acceptance; input changes after acceptance have no effect.
REQ-014 SHALL, in EXEC, drive alu_a=R[rs], alu_b=R[rt], alu_select=op and alu_en=1, and capture alu_out/alu_cout at the end of the cycle.
REQ-015 SHALL, outside EXEC, drive alu_en=0, alu_select=0, alu_a=0 and alu_b=0.
REQ-016 SHALL, in WB, write R[rd]=captured result, set carry_flag=captured cout for ops 0001/0010, clear it for ops 0011-0110, and pulse done=1 for that cycle.
REQ-017 SHALL complete an instruction in 3 cycles (accept edge to done), giving a maximum throughput of 1 per 3 cycles.
REQ-018 SHALL treat legal ops as 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR and 0110 NOT(A).
REQ-019 SHALL handle any other op by still passing through EXEC/WB but performing no register write, leaving carry_flag unchanged, giving done=0, and pulsing op_err=1 in WB.
REQ-020 SHALL accept external writes (wr_en) only in IDLE and ignore them silently while busy.
REQ-021 SHALL, for an external write in the same IDLE cycle an instruction is accepted, commit the write and have EXEC read the new value.
REQ-022 SHALL permit rs==rt==rd; operands are read in EXEC and writeback occurs in WB, so no hazard exists.
REQ-023 SHALL drive rd_data=R[rd_addr] combinationally, reflecting a write on the cycle after the write edge.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear R0..R3 to 0x00, carry_flag to 0, done to 0, op_err to 0, the captured result to 0, and force state to IDLE (instr_ready=1, alu_en=0).
REQ-025 SHALL, on rst asserted in EXEC or WB, abort the instruction with no writeback and no done.
REQ-026 SHALL give rst priority over wr_en and instr_valid.

Configuration
REQ-027 SHALL, when macro ALU_SEQ_ZERO_FLAG_EN is defined, add output zero_flag (1 bit) set in WB to (result==0) for legal ops, held otherwise, and reset to 0.
REQ-028 SHALL, when ALU_SEQ_ZERO_FLAG_EN is undefined, omit the zero_flag port and its logic entirely, with all other behaviour identical.

Verification
REQ-029 SHALL cover: load R0=0xF0, R1=0x20; ADD rd=2,rs=0,rt=1 -> in EXEC alu_select=0001, alu_a=0xF0, alu_b=0x20; in WB R2=0x10, carry_flag=1, done=1 three cycles after accept.
REQ-030 SHALL cover: R0=0x05, R1=0x07; SUB rd=3 -> R3=0xFE, carry_flag=0; then AND of 0xFE and 0x07 -> 0x06, carry_flag=0.
REQ-031 SHALL cover: op=1111 -> op_err pulse in WB, done=0, all registers and carry_flag unchanged.
REQ-032 SHALL cover: wr_en with wr_addr=1, wr_data=0xAA during EXEC -> R1 unchanged; the same write in IDLE together with accept of XOR rs=1,rt=1 -> result 0x00.
REQ-033 SHALL cover: rst asserted in the EXEC cycle of ADD into R2 -> R2=0x00, no done, instr_ready=1 next cycle.
REQ-034 SHALL cover: with ALU_SEQ_ZERO_FLAG_EN defined, SUB 0x33-0x33 -> zero_flag=1 and carry_flag=1; with the macro undefined, the design compiles without the zero_flag port.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: three-state (IDLE/EXEC/WB) controller that sequences one
// instruction at a time through an external 8-bit ALU, using a 4 x 8-bit
// register file for operands and results.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the zero_flag output.
module alu_op_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [3:0] instr_op,
   input  logic [1:0] instr_rd,
   input  logic [1:0] instr_rs,
   input  logic [1:0] instr_rt,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_select,
   output logic       alu_en,
   input  logic [7:0] alu_out,
   input  logic       alu_cout,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       carry_flag,
   output logic       op_err
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic       zero_flag
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t     state_reg, state_next;

   logic [3:0] op_reg;
   logic [1:0] rd_reg, rs_reg, rt_reg;
   logic [7:0] result_reg;
   logic       cout_reg;
   logic       carry_reg;
   logic [7:0] regs_reg [4];

   logic       accept;
   logic       in_exec, in_wb;
   logic       legal_op;
   logic       carry_op;
   logic       ext_write;
   logic       wb_write;
   logic [3:0] ext_sel;
   logic [3:0] wb_sel;

   assign in_exec   = (state_reg == EXEC);
   assign in_wb     = (state_reg == WB);
   assign accept    = instr_valid && instr_ready;

   // Only ops 0001..0110 are legal; ADD/SUB are the ones that report a carry.
   assign legal_op  = (op_reg >= 4'd1) && (op_reg <= 4'd6);
   assign carry_op  = (op_reg == 4'd1) || (op_reg == 4'd2);

   // External loads are only honoured while idle; writes while busy are dropped.
   assign ext_write = wr_en && (state_reg == IDLE);
   assign wb_write  = in_wb && legal_op;

   // Per-entry write decode for the register file.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sel
         assign ext_sel[gi] = ext_write && (wr_addr == gi[1:0]);
         assign wb_sel[gi]  = wb_write  && (rd_reg  == gi[1:0]);
      end
   endgenerate

   // Next-state and handshake logic.
   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            instr_ready = 1'b1;
            if (accept) state_next = EXEC;
         end
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = ~instr_ready;

   // ALU drive: operands and select only during EXEC, quiet zeros elsewhere.
   always_comb begin
      alu_en     = 1'b0;
      alu_select = 4'd0;
      alu_a      = 8'd0;
      alu_b      = 8'd0;
      if (in_exec) begin
         alu_en     = 1'b1;
         alu_select = op_reg;
         alu_a      = regs_reg[rs_reg];
         alu_b      = regs_reg[rt_reg];
      end
   end

   // Writeback pulses; a reset arriving in WB suppresses them along with the write.
   assign done   = in_wb &&  legal_op && !rst;
   assign op_err = in_wb && !legal_op && !rst;

   assign carry_flag = carry_reg;
   assign rd_data    = regs_reg[rd_addr];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Instruction fields are frozen at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg <= 4'd0;
         rd_reg <= 2'd0;
         rs_reg <= 2'd0;
         rt_reg <= 2'd0;
      end else if (accept) begin
         op_reg <= instr_op;
         rd_reg <= instr_rd;
         rs_reg <= instr_rs;
         rt_reg <= instr_rt;
      end
   end

   // Capture the ALU result and carry at the end of EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= 8'd0;
         cout_reg   <= 1'b0;
      end else if (in_exec) begin
         result_reg <= alu_out;
         cout_reg   <= alu_cout;
      end
   end

   // Register file: writeback and external load never overlap (WB vs IDLE).
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst)             regs_reg[i] <= 8'd0;
         else if (wb_sel[i])  regs_reg[i] <= result_reg;
         else if (ext_sel[i]) regs_reg[i] <= wr_data;
      end
   end

   // Carry flag follows ADD/SUB, is cleared by logic ops, held on illegal ops.
   always_ff @(posedge clk) begin
      if (rst)           carry_reg <= 1'b0;
      else if (wb_write) carry_reg <= carry_op ? cout_reg : 1'b0;
   end

`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic zero_reg;

   // Zero flag reflects the last legal result.
   always_ff @(posedge clk) begin
      if (rst)           zero_reg <= 1'b0;
      else if (wb_write) zero_reg <= (result_reg == 8'd0);
   end

   assign zero_flag = zero_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer. Models the external
// ALU combinationally and keeps an architectural reference of the register
// file and flags, updated once per completed instruction.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_rd, instr_rs, instr_rt;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_select;
   logic       alu_en;
   logic [7:0] alu_out;
   logic       alu_cout;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy, done, carry_flag, op_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic       zero_flag;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_r [4];
   logic       ref_carry;
   logic       ref_zero;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_en(alu_en),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .carry_flag(carry_flag), .op_err(op_err)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , .zero_flag(zero_flag)
`endif
   );

   // Arithmetic meaning of each op; SUB carry means "no borrow" (a >= b).
   function automatic void ref_alu(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, output logic [7:0] r,
                                   output logic c);
      int ia, ib;
      ia = a; ib = b;
      c = 1'b0;
      case (op)
         4'd1: begin r = 8'((ia + ib) % 256); c = (ia + ib) > 255; end
         4'd2: begin r = 8'((ia - ib + 256) % 256); c = (ia >= ib); end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: r = ~a;
         default: begin r = a ^ b ^ 8'h5A; c = 1'b1; end
      endcase
   endfunction

   // External ALU driven from the sequencer outputs.
   always_comb begin
      logic [7:0] r;
      logic       c;
      ref_alu(alu_select, alu_a, alu_b, r, c);
      alu_out  = r;
      alu_cout = c;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         #1;
         check($sformatf("%s R%0d", tag, i), rd_data, ref_r[i]);
      end
      check({tag, " carry"}, carry_flag, ref_carry);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      check({tag, " zero"}, zero_flag, ref_zero);
`endif
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
      ref_carry = 1'b0;
      ref_zero  = 1'b0;
   endtask

   task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      ref_r[a] = d;
      rd_addr = a;
      #1;
      check("load", rd_data, d);
      $display("LOAD R%0d=%02h", a, d);
   endtask

   // One instruction. wr_same: external write in the accept cycle.
   // busy_wr: junk writes during EXEC/WB. rst_exec: reset in EXEC.
   task automatic run_instr(input logic [3:0] op, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [1:0] rt,
                            input bit wr_same, input logic [1:0] wa, input logic [7:0] wd,
                            input bit busy_wr, input bit rst_exec);
      logic [7:0] r;
      logic       c;
      bit         legal;
      legal = (op >= 4'd1) && (op <= 4'd6);

      @(negedge clk);
      check("ready idle", instr_ready, 1'b1);
      check("busy idle", busy, 1'b0);
      instr_valid = 1'b1;
      instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
      if (wr_same) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end

      @(negedge clk);
      if (wr_same) ref_r[wa] = wd;
      instr_valid = 1'b0;
      instr_op = 4'($urandom); instr_rd = 2'($urandom);
      instr_rs = 2'($urandom); instr_rt = 2'($urandom);
      wr_en = busy_wr; wr_addr = 2'($urandom); wr_data = 8'($urandom);
      check("exec alu_en", alu_en, 1'b1);
      check("exec select", alu_select, op);
      check("exec alu_a", alu_a, ref_r[rs]);
      check("exec alu_b", alu_b, ref_r[rt]);
      check("exec busy", busy, 1'b1);
      check("exec done", done, 1'b0);

      if (rst_exec) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         wr_en = 1'b0;
         model_reset();
         check("abort ready", instr_ready, 1'b1);
         check("abort alu_en", alu_en, 1'b0);
         check("abort done", done, 1'b0);
         check_regs("abort");
         $display("INSTR op=%h rd=%0d rs=%0d rt=%0d aborted by reset", op, rd, rs, rt);
         return;
      end

      @(negedge clk);
      check("wb alu_en", alu_en, 1'b0);
      check("wb alu_a", alu_a, 8'h00);
      check("wb select", alu_select, 4'h0);
      check("wb done", done, legal);
      check("wb op_err", op_err, !legal);
      check("wb ready", instr_ready, 1'b0);

      @(negedge clk);
      wr_en = 1'b0;
      ref_alu(op, ref_r[rs], ref_r[rt], r, c);
      if (legal) begin
         ref_r[rd] = r;
         ref_carry = (op == 4'd1 || op == 4'd2) ? c : 1'b0;
         ref_zero  = (r == 8'h00);
      end
      check("idle done", done, 1'b0);
      check("idle op_err", op_err, 1'b0);
      check("idle ready", instr_ready, 1'b1);
      check_regs("post");
      $display("INSTR op=%h rd=%0d rs=%0d rt=%0d legal=%0d res=%02h carry=%0d",
               op, rd, rs, rt, legal, r, ref_carry);
   endtask

   initial begin
      rst = 1'b1;
      instr_valid = 1'b0; instr_op = 4'd0; instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0;
      wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0; rd_addr = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst ready", instr_ready, 1'b1);
      check("rst busy", busy, 1'b0);
      check("rst alu_en", alu_en, 1'b0);
      check("rst done", done, 1'b0);
      check("rst op_err", op_err, 1'b0);
      check_regs("rst");
      rst = 1'b0;

      // ADD 0xF0 + 0x20 -> 0x10 with carry
      load_reg(2'd0, 8'hF0);
      load_reg(2'd1, 8'h20);
      run_instr(4'd1, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'd0, 0, 0);
      check("add R2", ref_r[2] == 8'h10 && ref_carry, 1'b1);

      // SUB 5 - 7 -> 0xFE borrow, then AND 0xFE & 0x07 -> 0x06
      load_reg(2'd0, 8'h05);
      load_reg(2'd1, 8'h07);
      run_instr(4'd2, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'd0, 0, 0);
      run_instr(4'd3, 2'd2, 2'd3, 2'd1, 0, 2'd0, 8'd0, 0, 0);

      // Illegal op: no change, op_err only
      run_instr(4'hF, 2'd0, 2'd3, 2'd1, 0, 2'd0, 8'd0, 0, 0);

      // Write while busy is dropped; write at accept is seen by EXEC
      load_reg(2'd1, 8'h55);
      @(negedge clk);
      instr_valid = 1'b1; instr_op = 4'd4; instr_rd = 2'd0; instr_rs = 2'd2; instr_rt = 2'd3;
      @(negedge clk);
      instr_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hAA;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      ref_r[0] = ref_r[2] | ref_r[3]; ref_carry = 1'b0; ref_zero = (ref_r[0] == 8'h00);
      check_regs("busywr");
      run_instr(4'd5, 2'd2, 2'd1, 2'd1, 1, 2'd1, 8'hAA, 0, 0);

      // Reset in EXEC of ADD into R2
      load_reg(2'd2, 8'h77);
      run_instr(4'd1, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'd0, 1, 1);

      // SUB equal operands -> zero, carry set
      load_reg(2'd0, 8'h33);
      load_reg(2'd1, 8'h33);
      run_instr(4'd2, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'd0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         logic [3:0] op;
         if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
         else                           op = 4'($urandom);
         if ($urandom_range(0, 3) == 0) load_reg(2'($urandom), 8'($urandom));
         run_instr(op, 2'($urandom), 2'($urandom), 2'($urandom),
                   $urandom_range(0, 2) == 0, 2'($urandom), 8'($urandom),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
